// File: rtl/motion_timer.sv
// motion_timer: timed motion-command executor for the robot drive.
//
// Counts rising edges of the divided clock (tick_in) as time units and drives
// the 4-bit H-bridge pattern for the commanded number of ticks. One command is
// active and one can wait in a pending slot. A reversal between two different
// non-STOP ops inserts DEAD_CYC system cycles with every motor line low.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   tick_in    divided clock, asynchronous; synchronized internally
//   cmd_valid  command offered
//   cmd_ready  pending slot empty, abort low (and no watchdog fault)
//   cmd_op     0 STOP, 1 FWD, 2 REV, 3 LEFT, 4 RIGHT, 5-7 treated as STOP
//   cmd_dur    duration in ticks
//   abort      immediate stop and flush of active and pending commands
//   motor      {l_fwd, l_rev, r_fwd, r_rev}
//   busy       FSM not idle, or pending slot full
//   done       one-cycle pulse per completed command
//   remaining  ticks left on the active command, 0 when idle
//   fault      sticky watchdog fault (constant 0 unless MOTION_WDOG_EN)
//
// Build option: define MOTION_WDOG_EN to build the RUN-state watchdog, which
// aborts and raises fault if no tick arrives within WDOG_CYC cycles.

module motion_timer #(
  parameter int unsigned DUR_W    = 8,
  parameter int unsigned DEAD_CYC = 16,
  parameter int unsigned WDOG_CYC = 200000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [DUR_W-1:0] cmd_dur,
  input  logic             abort,
  output logic [3:0]       motor,
  output logic             busy,
  output logic             done,
  output logic [DUR_W-1:0] remaining,
  output logic             fault
);

  localparam logic [2:0] OP_STOP  = 3'd0;
  localparam logic [2:0] OP_FWD   = 3'd1;
  localparam logic [2:0] OP_REV   = 3'd2;
  localparam logic [2:0] OP_LEFT  = 3'd3;
  localparam logic [2:0] OP_RIGHT = 3'd4;

  localparam int unsigned DC_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DEAD
  } state_t;

  function automatic logic [2:0] norm_op(input logic [2:0] op);
    return (op > OP_RIGHT) ? OP_STOP : op;
  endfunction

  function automatic logic [3:0] pattern(input logic [2:0] op);
    case (op)
      OP_FWD:   pattern = 4'b1010;
      OP_REV:   pattern = 4'b0101;
      OP_LEFT:  pattern = 4'b0110;
      OP_RIGHT: pattern = 4'b1001;
      default:  pattern = 4'b0000;
    endcase
  endfunction

  state_t            state;
  logic              s1, s2, s3;
  logic              tick_pulse;
  logic              pend_valid;
  logic [2:0]        pend_op;
  logic [DUR_W-1:0]  pend_dur;
  logic [2:0]        act_op;
  logic [DC_W-1:0]   dead_cnt;
  logic              accept;
  logic              wdog_trip;
  logic              stop_all;
  logic              complete;
  logic              seamless;
  logic              dead_last;
  logic              load;

  // Tick synchronizer and rising-edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tick_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick_pulse = s2 & ~s3;

  assign cmd_ready = ~pend_valid & ~abort & ~fault;
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = (state != S_IDLE) | pend_valid;
  assign stop_all  = abort | wdog_trip;

  // A zero-duration command sits in RUN with remaining == 0 for one cycle and
  // completes without waiting for a tick.
  assign complete  = (state == S_RUN) &&
                     ((remaining == '0) || (tick_pulse && (remaining == DUR_W'(1))));
  assign seamless  = (pend_op == act_op) || (pend_op == OP_STOP) || (act_op == OP_STOP);
  assign dead_last = (state == S_DEAD) && (dead_cnt == DC_W'(DEAD_CYC - 1));

  // Every path that moves the pending command into the active slot.
  assign load = ~stop_all & pend_valid &
                (((state == S_IDLE) & ~fault) | (complete & seamless) | dead_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      motor      <= '0;
      done       <= 1'b0;
      remaining  <= '0;
      pend_valid <= 1'b0;
      pend_op    <= OP_STOP;
      pend_dur   <= '0;
      act_op     <= OP_STOP;
      dead_cnt   <= '0;
    end else begin
      done <= complete & ~stop_all;

      if (accept) begin
        pend_valid <= 1'b1;
        pend_op    <= norm_op(cmd_op);
        pend_dur   <= cmd_dur;
      end

      if (stop_all) begin
        state      <= S_IDLE;
        motor      <= '0;
        remaining  <= '0;
        pend_valid <= 1'b0;
        dead_cnt   <= '0;
      end else if (load) begin
        state      <= S_RUN;
        act_op     <= pend_op;
        remaining  <= pend_dur;
        motor      <= (pend_dur == '0) ? 4'b0000 : pattern(pend_op);
        pend_valid <= 1'b0;
      end else begin
        case (state)
          S_RUN: begin
            if (complete) begin
              motor <= '0;
              if (pend_valid) begin
                // Only a non-seamless successor reaches here (reversal).
                state    <= S_DEAD;
                dead_cnt <= '0;
              end else begin
                state     <= S_IDLE;
                remaining <= '0;
              end
            end else if (tick_pulse) begin
              remaining <= remaining - DUR_W'(1);
            end
          end
          S_DEAD: begin
            motor    <= '0;
            dead_cnt <= dead_cnt + DC_W'(1);
          end
          S_IDLE: begin
            motor <= '0;
          end
          default: begin
            state <= S_IDLE;
            motor <= '0;
          end
        endcase
      end
    end
  end

`ifdef MOTION_WDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_CYC + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            fault_q;

  // Trip on the cycle the count would reach WDOG_CYC without a tick.
  assign wdog_trip = (state == S_RUN) && !tick_pulse && (wd_cnt == WD_W'(WDOG_CYC - 1));
  assign fault     = fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= '0;
      fault_q <= 1'b0;
    end else begin
      if ((state != S_RUN) || tick_pulse || wdog_trip)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + WD_W'(1);
      if (wdog_trip)
        fault_q <= 1'b1;
    end
  end
`else
  logic unused_wdog;

  assign wdog_trip   = 1'b0;
  assign fault       = 1'b0;
  assign unused_wdog = ^WDOG_CYC;
`endif

endmodule

// File: tb/tb_motion_timer.sv
// Directed bench for motion_timer: single command, dead-time reversal,
// seamless same-op chaining, STOP pause (including ops 5-7), zero duration,
// abort with a queued command, and the watchdog (MOTION_WDOG_EN builds).

module tb_motion_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_in;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_dur;
  logic       abort;
  logic [3:0] motor;
  logic       busy;
  logic       done;
  logic [7:0] remaining;
  logic       fault;

  int n_cmp = 0;
  int n_err = 0;
  int done_total = 0;
  int zero_cnt = 0;
  bit nz_seen = 1'b0;

  motion_timer #(
    .DUR_W   (8),
    .DEAD_CYC(16),
    .WDOG_CYC(100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_in  (tick_in),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_dur  (cmd_dur),
    .abort    (abort),
    .motor    (motor),
    .busy     (busy),
    .done     (done),
    .remaining(remaining),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_total++;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (motor === 4'b0000) zero_cnt++;
    else nz_seen = 1'b1;
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] dur);
    int w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin
      step();
      w++;
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL send_ready: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dur   = dur;
    step();
    cmd_valid = 1'b0;
  endtask

  // One tick period (10 high, 10 low); outputs sampled 3 cycles after the rise,
  // the first cycle an effect of the tick is visible.
  task automatic do_tick(output logic [3:0] m3, output logic [7:0] r3, output logic d3);
    tick_in = 1'b1;
    step(); step(); step();
    m3 = motor;
    r3 = remaining;
    d3 = done;
    repeat (7) step();
    tick_in = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick_in = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_dur = '0; abort = 1'b0;
    repeat (3) step();
    n_cmp++; if (motor !== 4'b0000) begin n_err++; $display("FAIL reset_motor: got %b want 0000", motor); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (remaining !== 8'd0) begin n_err++; $display("FAIL reset_remaining: got %0d want 0", remaining); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", fault); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_fwd();
    logic [3:0] m; logic [7:0] r; logic d; int d0;
    d0 = done_total;
    send(3'd1, 8'd3);
    n_cmp++; if (motor !== 4'b0000) begin n_err++; $display("FAIL fwd_accept1_motor: got %b want 0000", motor); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL fwd_accept1_busy: got %b want 1", busy); end
    step();
    n_cmp++; if (motor !== 4'b1010) begin n_err++; $display("FAIL fwd_accept2_motor: got %b want 1010", motor); end
    n_cmp++; if (remaining !== 8'd3) begin n_err++; $display("FAIL fwd_load_rem: got %0d want 3", remaining); end
    do_tick(m, r, d);
    n_cmp++; if (r !== 8'd2) begin n_err++; $display("FAIL fwd_tick1_rem: got %0d want 2", r); end
    do_tick(m, r, d);
    n_cmp++; if (r !== 8'd1) begin n_err++; $display("FAIL fwd_tick2_rem: got %0d want 1", r); end
    n_cmp++; if (m !== 4'b1010) begin n_err++; $display("FAIL fwd_tick2_motor: got %b want 1010", m); end
    do_tick(m, r, d);
    n_cmp++; if (d !== 1'b1) begin n_err++; $display("FAIL fwd_done: got %b want 1", d); end
    n_cmp++; if (m !== 4'b0000) begin n_err++; $display("FAIL fwd_end_motor: got %b want 0000", m); end
    n_cmp++; if (r !== 8'd0) begin n_err++; $display("FAIL fwd_end_rem: got %0d want 0", r); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fwd_end_busy: got %b want 0", busy); end
    n_cmp++; if (done_total - d0 !== 1) begin n_err++; $display("FAIL fwd_done_count: got %0d want 1", done_total - d0); end
  endtask

  task automatic test_dead_time();
    logic [3:0] m; logic [7:0] r; logic d; int d0;
    d0 = done_total;
    send(3'd1, 8'd2);
    send(3'd2, 8'd2);
    n_cmp++; if (motor !== 4'b1010) begin n_err++; $display("FAIL dead_first_motor: got %b want 1010", motor); end
    zero_cnt = 0;
    do_tick(m, r, d);
    n_cmp++; if (r !== 8'd1) begin n_err++; $display("FAIL dead_tick1_rem: got %0d want 1", r); end
    do_tick(m, r, d);
    n_cmp++; if (d !== 1'b1 || m !== 4'b0000) begin n_err++; $display("FAIL dead_first_done: got done=%b motor=%b want done=1 motor=0000", d, m); end
    n_cmp++; if (zero_cnt !== 16) begin n_err++; $display("FAIL dead_gap_len: got %0d want 16", zero_cnt); end
    n_cmp++; if (motor !== 4'b0101) begin n_err++; $display("FAIL dead_rev_motor: got %b want 0101", motor); end
    n_cmp++; if (remaining !== 8'd2) begin n_err++; $display("FAIL dead_rev_rem: got %0d want 2", remaining); end
    do_tick(m, r, d);
    do_tick(m, r, d);
    n_cmp++; if (d !== 1'b1 || m !== 4'b0000) begin n_err++; $display("FAIL dead_rev_done: got done=%b motor=%b want done=1 motor=0000", d, m); end
    n_cmp++; if (done_total - d0 !== 2) begin n_err++; $display("FAIL dead_done_count: got %0d want 2", done_total - d0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dead_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_seamless();
    logic [3:0] m; logic [7:0] r; logic d; int d0;
    d0 = done_total;
    send(3'd1, 8'd2);
    send(3'd1, 8'd1);
    n_cmp++; if (remaining !== 8'd2) begin n_err++; $display("FAIL seam_load_rem: got %0d want 2", remaining); end
    zero_cnt = 0;
    do_tick(m, r, d);
    n_cmp++; if (r !== 8'd1) begin n_err++; $display("FAIL seam_tick1_rem: got %0d want 1", r); end
    do_tick(m, r, d);
    n_cmp++; if (r !== 8'd1 || m !== 4'b1010 || d !== 1'b1) begin n_err++; $display("FAIL seam_handover: got rem=%0d motor=%b done=%b want rem=1 motor=1010 done=1", r, m, d); end
    n_cmp++; if (zero_cnt !== 0) begin n_err++; $display("FAIL seam_no_gap: got %0d zero cycles want 0", zero_cnt); end
    do_tick(m, r, d);
    n_cmp++; if (r !== 8'd0 || m !== 4'b0000 || d !== 1'b1) begin n_err++; $display("FAIL seam_end: got rem=%0d motor=%b done=%b want rem=0 motor=0000 done=1", r, m, d); end
    n_cmp++; if (done_total - d0 !== 2) begin n_err++; $display("FAIL seam_done_count: got %0d want 2", done_total - d0); end
  endtask

  task automatic test_stop_pause();
    logic [3:0] m; logic [7:0] r; logic d; int d0;
    d0 = done_total;
    send(3'd6, 8'd1);
    step();
    n_cmp++; if (motor !== 4'b0000 || busy !== 1'b1 || remaining !== 8'd1) begin n_err++; $display("FAIL stop_load: got motor=%b busy=%b rem=%0d want motor=0000 busy=1 rem=1", motor, busy, remaining); end
    send(3'd1, 8'd1);
    do_tick(m, r, d);
    n_cmp++; if (m !== 4'b1010 || r !== 8'd1 || d !== 1'b1) begin n_err++; $display("FAIL stop_to_fwd: got motor=%b rem=%0d done=%b want motor=1010 rem=1 done=1", m, r, d); end
    do_tick(m, r, d);
    n_cmp++; if (m !== 4'b0000 || d !== 1'b1) begin n_err++; $display("FAIL stop_fwd_end: got motor=%b done=%b want motor=0000 done=1", m, d); end
    n_cmp++; if (done_total - d0 !== 2) begin n_err++; $display("FAIL stop_done_count: got %0d want 2", done_total - d0); end
  endtask

  task automatic test_zero_dur();
    int d0;
    d0 = done_total;
    nz_seen = 1'b0;
    send(3'd3, 8'd0);
    step();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL zero_early_done: got %b want 0", done); end
    step();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %b want 0", busy); end
    repeat (5) step();
    n_cmp++; if (nz_seen !== 1'b0) begin n_err++; $display("FAIL zero_motor_active: got %b want 0", nz_seen); end
    n_cmp++; if (done_total - d0 !== 1) begin n_err++; $display("FAIL zero_done_count: got %0d want 1", done_total - d0); end
  endtask

  task automatic test_abort();
    logic [3:0] m; logic [7:0] r; logic d; int d0;
    d0 = done_total;
    send(3'd4, 8'd5);
    send(3'd1, 8'd3);
    do_tick(m, r, d);
    n_cmp++; if (r !== 8'd4 || m !== 4'b1001) begin n_err++; $display("FAIL abort_pre: got rem=%0d motor=%b want rem=4 motor=1001", r, m); end
    abort = 1'b1;
    step();
    n_cmp++; if (motor !== 4'b0000 || remaining !== 8'd0) begin n_err++; $display("FAIL abort_stop: got motor=%b rem=%0d want motor=0000 rem=0", motor, remaining); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_flush: got busy=%b want 0", busy); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL abort_ready_low: got %b want 0", cmd_ready); end
    abort = 1'b0;
    step();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready_back: got %b want 1", cmd_ready); end
    nz_seen = 1'b0;
    do_tick(m, r, d);
    do_tick(m, r, d);
    n_cmp++; if (nz_seen !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL abort_pending_gone: got motor_active=%b busy=%b want 0 0", nz_seen, busy); end
    n_cmp++; if (done_total - d0 !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d want 0", done_total - d0); end
  endtask

  task automatic test_watchdog();
`ifdef MOTION_WDOG_EN
    tick_in = 1'b0;
    send(3'd1, 8'd5);
    repeat (100) step();
    n_cmp++; if (fault !== 1'b0 || motor !== 4'b1010) begin n_err++; $display("FAIL wdog_before: got fault=%b motor=%b want 0 1010", fault, motor); end
    step();
    n_cmp++; if (fault !== 1'b1 || motor !== 4'b0000 || remaining !== 8'd0) begin n_err++; $display("FAIL wdog_trip: got fault=%b motor=%b rem=%0d want 1 0000 0", fault, motor, remaining); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL wdog_ready: got %b want 0", cmd_ready); end
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_dur = 8'd2;
    repeat (5) step();
    cmd_valid = 1'b0;
    n_cmp++; if (motor !== 4'b0000 || busy !== 1'b0 || fault !== 1'b1) begin n_err++; $display("FAIL wdog_refuse: got motor=%b busy=%b fault=%b want 0000 0 1", motor, busy, fault); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_cmp++; if (fault !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL wdog_clear: got fault=%b ready=%b want 0 1", fault, cmd_ready); end
`else
    logic [3:0] m; logic [7:0] r; logic d;
    tick_in = 1'b0;
    send(3'd1, 8'd1);
    repeat (150) step();
    n_cmp++; if (fault !== 1'b0 || motor !== 4'b1010) begin n_err++; $display("FAIL nowdog_long_run: got fault=%b motor=%b want 0 1010", fault, motor); end
    do_tick(m, r, d);
    n_cmp++; if (m !== 4'b0000 || d !== 1'b1) begin n_err++; $display("FAIL nowdog_end: got motor=%b done=%b want 0000 1", m, d); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_fwd();
    test_dead_time();
    test_seamless();
    test_stop_pause();
    test_zero_dur();
    test_abort();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
